// File: rtl/game_timer_if.sv
// game_timer_if: control inputs and status outputs of the game timer
interface game_timer_if;
  logic        start_n;
  logic        pause;
  logic        collision;
  logic        game_state;
  logic [31:0] game_time;
  logic        sec_tick;
  logic        time_sat;
  modport master(output start_n, pause, collision, input game_state, game_time, sec_tick, time_sat);
  modport slave(input start_n, pause, collision, output game_state, game_time, sec_tick, time_sat);
endinterface

// File: rtl/game_timer.sv
// game_timer: start-key synchronizer, IDLE/RUN/PAUSE/OVER FSM and saturating seconds counter (clk_50M, rst, bus: start_n/pause/collision in, game_state/game_time/sec_tick/time_sat out)
module game_timer #(
  parameter int CLK_FREQ = 50000000,
  parameter int MAX_TIME = 99
) (
  input logic         clk_50M,
  input logic         rst,
  game_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, OVER} state_t;
  state_t      r_state;
  logic        r_s1, r_s2, r_s3;
  logic [2:0]  r_vld;
  logic [25:0] r_presc;
  logic [6:0]  r_time;
  logic        r_tick, r_gs;
  logic        w_start, w_live, w_wrap;
  // r_vld blocks the false edge seen when the key is already held low as the idle-high reset values flush out
  assign w_start = r_vld[2] & r_s3 & ~r_s2;
  assign w_live  = (r_state == RUN) || (r_state == PAUSE);
  assign w_wrap  = r_presc == 26'(CLK_FREQ - 1);
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      r_state <= IDLE;
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_s3    <= 1'b1;
      r_vld   <= '0;
      r_presc <= '0;
      r_time  <= '0;
      r_tick  <= 1'b0;
      r_gs    <= 1'b0;
    end else begin
      r_s1   <= bus.start_n;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_vld  <= {r_vld[1:0], 1'b1};
      r_tick <= 1'b0;
      if (w_live) begin
        if (bus.collision) begin
          r_state <= OVER;
          r_gs    <= 1'b0;
          r_presc <= '0;
        end else if (bus.pause) r_state <= PAUSE;
        else begin
          r_state <= RUN;
          r_presc <= w_wrap ? '0 : r_presc + 26'd1;
          if (w_wrap && r_time < 7'(MAX_TIME)) begin
            r_time <= r_time + 7'd1;
            r_tick <= 1'b1;
          end
        end
      end else if (w_start && !(r_state == OVER && bus.collision)) begin
        r_state <= RUN;
        r_gs    <= 1'b1;
        r_time  <= '0;
        r_presc <= '0;
      end
    end
  end
  assign bus.game_state = r_gs;
  assign bus.game_time  = {25'd0, r_time};
  assign bus.sec_tick   = r_tick;
  assign bus.time_sat   = r_time == 7'(MAX_TIME);
endmodule

// File: tb/tb_game_timer.sv
// tb_game_timer: directed checks of game_timer with CLK_FREQ=10, MAX_TIME=5
module tb_game_timer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  game_timer_if bus();
  game_timer #(.CLK_FREQ(10), .MAX_TIME(5)) dut (.clk_50M(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic press();
    bus.start_n = 1'b0;
    step(1);
    bus.start_n = 1'b1;
  endtask
  initial begin
    int t;
    bus.start_n = 1'b1;
    bus.pause = 1'b0;
    bus.collision = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_state", {31'd0, bus.game_state}, 0);
    chk("rst_time", bus.game_time, 0);
    chk("rst_tick", {31'd0, bus.sec_tick}, 0);
    chk("rst_sat", {31'd0, bus.time_sat}, 0);
    step(4);
    press();
    step(1);
    chk("start_lat2", {31'd0, bus.game_state}, 0);
    step(1);
    chk("start_lat3", {31'd0, bus.game_state}, 1);
    step(9);
    chk("sec1_early", bus.game_time, 0);
    step(1);
    chk("sec1_time", bus.game_time, 1);
    chk("sec1_tick", {31'd0, bus.sec_tick}, 1);
    step(1);
    chk("tick_pulse", {31'd0, bus.sec_tick}, 0);
    step(9);
    chk("sec2_time", bus.game_time, 2);
    chk("sec2_tick", {31'd0, bus.sec_tick}, 1);
    step(3);
    bus.pause = 1'b1;
    step(25);
    chk("pause_time", bus.game_time, 2);
    chk("pause_state", {31'd0, bus.game_state}, 1);
    bus.pause = 1'b0;
    step(6);
    chk("resume_early", bus.game_time, 2);
    step(1);
    chk("resume_time", bus.game_time, 3);
    chk("resume_tick", {31'd0, bus.sec_tick}, 1);
    press();
    step(4);
    chk("norestart_time", bus.game_time, 3);
    chk("norestart_state", {31'd0, bus.game_state}, 1);
    step(4);
    bus.collision = 1'b1;
    step(1);
    bus.collision = 1'b0;
    chk("coll_state", {31'd0, bus.game_state}, 0);
    chk("coll_time", bus.game_time, 3);
    chk("coll_tick", {31'd0, bus.sec_tick}, 0);
    step(15);
    chk("over_hold", bus.game_time, 3);
    press();
    step(1);
    chk("over_prestart", bus.game_time, 3);
    step(1);
    chk("restart_state", {31'd0, bus.game_state}, 1);
    chk("restart_time", bus.game_time, 0);
    t = 0;
    repeat (80) begin
      step(1);
      t += int'(bus.sec_tick);
    end
    chk("sat_ticks", t, 5);
    chk("sat_time", bus.game_time, 5);
    chk("sat_flag", {31'd0, bus.time_sat}, 1);
    bus.collision = 1'b1;
    step(1);
    bus.collision = 1'b0;
    chk("coll2_state", {31'd0, bus.game_state}, 0);
    press();
    step(2);
    chk("game3_state", {31'd0, bus.game_state}, 1);
    step(40);
    chk("game3_time", bus.game_time, 4);
    chk("game3_sat", {31'd0, bus.time_sat}, 0);
    rst = 1'b1;
    bus.start_n = 1'b0;
    step(1);
    chk("abort_state", {31'd0, bus.game_state}, 0);
    chk("abort_time", bus.game_time, 0);
    chk("abort_tick", {31'd0, bus.sec_tick}, 0);
    step(2);
    rst = 1'b0;
    step(10);
    chk("held_idle", {31'd0, bus.game_state}, 0);
    bus.start_n = 1'b1;
    step(4);
    press();
    step(2);
    chk("rearm_state", {31'd0, bus.game_state}, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
